// File: rtl/mixer_tune_ctrl.sv
// mixer_tune_ctrl: retune controller for the mixer NCO.
// A new phase increment is accepted over valid/ready. It is applied only at an NCO
// phase wrap, or after WRAP_TIMEOUT cycles without one. The mixer stays muted while
// the increment changes and for SETTLE_CYCLES afterwards.
//
// Build option: define MIXER_TUNE_SLEW_EN to ramp phase_inc toward the target in
// steps of at most MAX_STEP per cycle. When it is undefined, phase_inc jumps in a
// single cycle.
module mixer_tune_ctrl #(
    parameter int unsigned            PHASE_WIDTH   = 32,
    parameter logic [PHASE_WIDTH-1:0] DEFAULT_INC   = '0,
    parameter int unsigned            SETTLE_CYCLES = 16,
    parameter int unsigned            WRAP_TIMEOUT  = 4096,
    parameter int unsigned            MAX_STEP      = 2**20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   tune_valid,
    output logic                   tune_ready,
    input  logic [PHASE_WIDTH-1:0] tune_inc,
    input  logic                   nco_wrap,
    output logic [PHASE_WIDTH-1:0] phase_inc,
    output logic                   phase_inc_load,
    output logic                   mix_mute,
    output logic                   busy,
    output logic                   tune_done,
    output logic                   wrap_timeout,
    output logic [15:0]            retune_count
);

`ifdef MIXER_TUNE_SLEW_EN
    localparam bit SlewEn = 1'b1;
`else
    localparam bit SlewEn = 1'b0;
`endif

    // Without slewing, the step is unlimited, so one APPLY step lands exactly on the target.
    localparam logic [PHASE_WIDTH-1:0] StepLimit = SlewEn ? PHASE_WIDTH'(MAX_STEP) : '1;

    // One counter is shared by the wrap wait and the settle window.
    localparam int unsigned CntMax = (WRAP_TIMEOUT > SETTLE_CYCLES) ? WRAP_TIMEOUT
                                                                    : SETTLE_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] WaitLast   = CntW'(WRAP_TIMEOUT - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitWrap,
        StApply,
        StSettle
    } state_e;

    state_e                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] pending_q, pending_d;
    logic [PHASE_WIDTH-1:0] phase_inc_q, phase_inc_d;
    logic                   load_q, load_d;
    logic                   mute_q, mute_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic [15:0]            count_q, count_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic                   step_up;
    logic [PHASE_WIDTH-1:0] diff;
    logic [PHASE_WIDTH-1:0] step;
    logic [PHASE_WIDTH-1:0] phase_step;

    // Next phase_inc one step toward pending, clamped to StepLimit (unsigned, no wrap).
    always_comb begin
        step_up    = (pending_q >= phase_inc_q);
        diff       = step_up ? (pending_q - phase_inc_q) : (phase_inc_q - pending_q);
        step       = (diff > StepLimit) ? StepLimit : diff;
        phase_step = step_up ? (phase_inc_q + step) : (phase_inc_q - step);
    end

    // Retune sequencing: next state, pending target, counters and status.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        phase_inc_d = phase_inc_q;
        load_d      = 1'b0;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        count_d     = count_q;
        cnt_d       = cnt_q;

        if (!enable) begin
            // Abort: drop any retune in flight and keep whatever increment is applied.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tune_valid) begin
                        pending_d = tune_inc;
                        if (tune_inc == phase_inc_q) begin
                            done_d = 1'b1;
                        end else begin
                            state_d   = StWaitWrap;
                            timeout_d = 1'b0;
                            cnt_d     = '0;
                        end
                    end
                end
                StWaitWrap: begin
                    if (nco_wrap || (cnt_q == WaitLast)) begin
                        state_d     = StApply;
                        phase_inc_d = phase_step;
                        load_d      = 1'b1;
                        if (!nco_wrap) begin
                            timeout_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StApply: begin
                    if (phase_inc_q == pending_q) begin
                        state_d = StSettle;
                        cnt_d   = SettleLast;
                    end else begin
                        phase_inc_d = phase_step;
                        load_d      = 1'b1;
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Mute is registered, so it follows enable and the next state.
        mute_d = !enable || (state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pending_q   <= DEFAULT_INC;
            phase_inc_q <= DEFAULT_INC;
            load_q      <= 1'b0;
            mute_q      <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            count_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            phase_inc_q <= phase_inc_d;
            load_q      <= load_d;
            mute_q      <= mute_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
        end
    end

    // Outputs: handshake and busy decode from state, the rest come straight from registers.
    always_comb begin
        tune_ready     = (state_q == StIdle) && enable;
        busy           = (state_q != StIdle);
        phase_inc      = phase_inc_q;
        phase_inc_load = load_q;
        mix_mute       = mute_q;
        tune_done      = done_q;
        wrap_timeout   = timeout_q;
        retune_count   = count_q;
    end

endmodule

// File: tb/tb_mixer_tune_ctrl.sv
// Self-checking bench for mixer_tune_ctrl: directed latency cases plus randomized
// traffic against a behavioural model of the retune rules.
module tb_mixer_tune_ctrl;

    localparam int unsigned PW      = 32;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned WTO     = 8;
    localparam int unsigned MAXSTEP = 'h100;
    localparam logic [31:0] DEF     = 32'h0000_0040;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable = 1'b0;
    logic          tune_valid = 1'b0;
    logic          tune_ready;
    logic [PW-1:0] tune_inc = '0;
    logic          nco_wrap = 1'b0;
    logic [PW-1:0] phase_inc;
    logic          phase_inc_load;
    logic          mix_mute;
    logic          busy;
    logic          tune_done;
    logic          wrap_timeout;
    logic [15:0]   retune_count;

    always #5 clk = ~clk;

    mixer_tune_ctrl #(
        .PHASE_WIDTH  (PW),
        .DEFAULT_INC  (DEF),
        .SETTLE_CYCLES(SETTLE),
        .WRAP_TIMEOUT (WTO),
        .MAX_STEP     (MAXSTEP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .tune_valid    (tune_valid),
        .tune_ready    (tune_ready),
        .tune_inc      (tune_inc),
        .nco_wrap      (nco_wrap),
        .phase_inc     (phase_inc),
        .phase_inc_load(phase_inc_load),
        .mix_mute      (mix_mute),
        .busy          (busy),
        .tune_done     (tune_done),
        .wrap_timeout  (wrap_timeout),
        .retune_count  (retune_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the applied increment, the target, and the time left in each phase
    // of a retune.
    longint unsigned m_phase, m_pend;
    bit              m_load, m_mute, m_done, m_timeout;
    int              m_count;
    bit              m_waiting, m_slewing;
    int              m_age, m_settle_left;

    function automatic bit model_busy();
        return m_waiting || m_slewing || (m_settle_left > 0);
    endfunction

    function automatic longint unsigned toward(longint unsigned cur, longint unsigned tgt);
`ifdef MIXER_TUNE_SLEW_EN
        if (tgt > cur) return (tgt - cur > MAXSTEP) ? cur + MAXSTEP : tgt;
        else           return (cur - tgt > MAXSTEP) ? cur - MAXSTEP : tgt;
`else
        return tgt + 0 * cur;
`endif
    endfunction

    task automatic model_reset();
        m_phase = DEF;  m_pend = DEF;
        m_load = 0;  m_mute = 1;  m_done = 0;  m_timeout = 0;  m_count = 0;
        m_waiting = 0;  m_slewing = 0;  m_age = 0;  m_settle_left = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input longint unsigned ti, input bit w);
        m_load = 0;
        m_done = 0;
        if (!e) begin
            m_waiting = 0;  m_slewing = 0;  m_settle_left = 0;
        end else if (m_waiting) begin
            if (w || m_age == WTO - 1) begin
                if (!w) m_timeout = 1;
                m_waiting = 0;
                m_slewing = 1;
                m_phase   = toward(m_phase, m_pend);
                m_load    = 1;
            end else begin
                m_age++;
            end
        end else if (m_slewing) begin
            if (m_phase == m_pend) begin
                m_slewing     = 0;
                m_settle_left = SETTLE;
            end else begin
                m_phase = toward(m_phase, m_pend);
                m_load  = 1;
            end
        end else if (m_settle_left > 0) begin
            m_settle_left--;
            if (m_settle_left == 0) begin
                m_done = 1;
                if (m_count < 65535) m_count++;
            end
        end else if (v) begin
            if (ti == m_phase) begin
                m_done = 1;
            end else begin
                m_pend    = ti;
                m_waiting = 1;
                m_age     = 0;
                m_timeout = 0;
            end
        end
        m_mute = !e || model_busy();
    endtask

    task automatic compare_all();
        check_eq("phase_inc", 64'(phase_inc), m_phase);
        check_eq("phase_inc_load", 64'(phase_inc_load), 64'(m_load));
        check_eq("mix_mute", 64'(mix_mute), 64'(m_mute));
        check_eq("busy", 64'(busy), 64'(model_busy()));
        check_eq("tune_ready", 64'(tune_ready), 64'(!model_busy() && enable));
        check_eq("tune_done", 64'(tune_done), 64'(m_done));
        check_eq("wrap_timeout", 64'(wrap_timeout), 64'(m_timeout));
        check_eq("retune_count", 64'(retune_count), 64'(m_count));
    endtask

    // One clock: the DUT and model see the same inputs, then outputs are compared 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step(enable, tune_valid, 64'(tune_inc), nco_wrap);
        #1;
        compare_all();
    endtask

    initial begin
        int cyc;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        compare_all();
        check_eq("reset_phase", 64'(phase_inc), 64'(DEF));
        check_eq("reset_mute", 64'(mix_mute), 64'(1));
        #10 rst_n = 1'b1;

        enable = 1'b1;
        repeat (4) tick();
        check_eq("idle_unmuted", 64'(mix_mute), 64'(0));

`ifndef MIXER_TUNE_SLEW_EN
        // Normal retune: accept in cycle 0, wrap in cycle 5.
        for (int c = 0; c < 11; c++) begin
            tune_valid = (c == 0);
            tune_inc   = 32'h0100_0000;
            nco_wrap   = (c == 5);
            tick();
            cyc = c + 1;
            if (cyc == 5) check_eq("wait_no_load", 64'(phase_inc_load), 64'(0));
            if (cyc == 6) begin
                check_eq("apply_load", 64'(phase_inc_load), 64'(1));
                check_eq("apply_value", 64'(phase_inc), 64'h0100_0000);
            end
            if (cyc <= 10) begin
                check_eq("retune_mute", 64'(mix_mute), 64'(1));
                check_eq("retune_not_ready", 64'(tune_ready), 64'(0));
            end
            if (cyc == 11) begin
                check_eq("done_pulse", 64'(tune_done), 64'(1));
                check_eq("count_one", 64'(retune_count), 64'(1));
                check_eq("mute_release", 64'(mix_mute), 64'(0));
            end
        end
        nco_wrap = 1'b0;

        // Timeout: the wrap coincident with accept is ignored, so no wrap is seen.
        for (int c = 0; c < 14; c++) begin
            tune_valid = (c == 0);
            tune_inc   = 32'h0023_4560;
            nco_wrap   = (c == 0);
            tick();
            cyc = c + 1;
            if (cyc == 8) begin
                check_eq("to_still_wait", 64'(busy), 64'(1));
                check_eq("to_no_load_yet", 64'(phase_inc_load), 64'(0));
            end
            if (cyc == 9) begin
                check_eq("to_apply_load", 64'(phase_inc_load), 64'(1));
                check_eq("to_apply_value", 64'(phase_inc), 64'h0023_4560);
                check_eq("to_flag", 64'(wrap_timeout), 64'(1));
            end
            if (cyc == 14) begin
                check_eq("to_done", 64'(tune_done), 64'(1));
                check_eq("to_count", 64'(retune_count), 64'(2));
            end
        end
        nco_wrap = 1'b0;
        repeat (3) tick();
        check_eq("to_sticky", 64'(wrap_timeout), 64'(1));

        // Same-value request completes immediately with no mute and no load.
        tune_valid = 1'b1;
        tune_inc   = 32'h0023_4560;
        tick();
        tune_valid = 1'b0;
        check_eq("same_done", 64'(tune_done), 64'(1));
        check_eq("same_no_mute", 64'(mix_mute), 64'(0));
        check_eq("same_no_load", 64'(phase_inc_load), 64'(0));
        check_eq("same_count", 64'(retune_count), 64'(2));
        tick();

        // Abort in SETTLE: accept c0, wrap c1, APPLY c2, SETTLE from c3, enable low in c4.
        for (int c = 0; c < 5; c++) begin
            enable     = (c != 4);
            tune_valid = (c == 0);
            tune_inc   = 32'h0055_0000;
            nco_wrap   = (c == 1);
            tick();
            if (c + 1 == 5) begin
                check_eq("abort_idle", 64'(busy), 64'(0));
                check_eq("abort_mute", 64'(mix_mute), 64'(1));
                check_eq("abort_no_done", 64'(tune_done), 64'(0));
                check_eq("abort_keeps_phase", 64'(phase_inc), 64'h0055_0000);
            end
        end
        enable     = 1'b1;
        tune_valid = 1'b0;
        nco_wrap   = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_eq("abort_no_late_done", 64'(tune_done), 64'(0));
        end
        check_eq("abort_count", 64'(retune_count), 64'(2));

        // Abort in WAIT_WRAP leaves phase_inc untouched.
        for (int c = 0; c < 5; c++) begin
            enable     = (c != 2);
            tune_valid = (c == 0);
            tune_inc   = 32'h0077_0000;
            nco_wrap   = (c == 3);
            tick();
        end
        tune_valid = 1'b0;
        nco_wrap   = 1'b0;
        check_eq("wait_abort_phase", 64'(phase_inc), 64'h0055_0000);
        check_eq("wait_abort_idle", 64'(busy), 64'(0));
`else
        // Slew: go to 0, then ramp 0 -> 0x350 in steps of 0x100.
        for (int c = 0; c < 10; c++) begin
            tune_valid = (c == 0);
            tune_inc   = 32'h0;
            nco_wrap   = (c == 1);
            tick();
        end
        check_eq("slew_at_zero", 64'(phase_inc), 64'(0));
        for (int c = 0; c < 12; c++) begin
            tune_valid = (c == 0);
            tune_inc   = 32'h350;
            nco_wrap   = (c == 1);
            tick();
            cyc = c + 1;
            if (cyc == 2) check_eq("slew_s1", 64'(phase_inc), 64'h100);
            if (cyc == 3) check_eq("slew_s2", 64'(phase_inc), 64'h200);
            if (cyc == 4) check_eq("slew_s3", 64'(phase_inc), 64'h300);
            if (cyc == 5) check_eq("slew_s4", 64'(phase_inc), 64'h350);
            if (cyc >= 2 && cyc <= 5) check_eq("slew_load", 64'(phase_inc_load), 64'(1));
            if (cyc == 6) begin
                check_eq("slew_settle_no_load", 64'(phase_inc_load), 64'(0));
                check_eq("slew_settle_busy", 64'(busy), 64'(1));
            end
            if (cyc == 10) check_eq("slew_done", 64'(tune_done), 64'(1));
        end
        tune_valid = 1'b0;
        nco_wrap   = 1'b0;
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            enable     = ($urandom_range(0, 19) != 0);
            tune_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tune_inc = 32'(m_phase);
            end else begin
`ifdef MIXER_TUNE_SLEW_EN
                tune_inc = $urandom_range(0, 'h600);
`else
                tune_inc = $urandom;
`endif
            end
            nco_wrap = ($urandom_range(0, 5) == 0);
            tick();
        end

        // Asynchronous reset asserted mid-cycle.
        enable     = 1'b1;
        tune_valid = 1'b1;
        tune_inc   = 32'h0000_0123;
        tick();
        tune_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("async_rst_phase", 64'(phase_inc), 64'(DEF));
        check_eq("async_rst_mute", 64'(mix_mute), 64'(1));
        check_eq("async_rst_count", 64'(retune_count), 64'(0));
        @(posedge clk);
        #1;
        compare_all();
        #2 rst_n = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
